// File: rtl/ul_drp_cfg_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : ul_drp_cfg_mp_if
// Description : Command/readback stream and multi-port DRP/GPIO bus bundle
//               for the ul_drp_cfg_mp configuration bridge. The slave view
//               is taken by the bridge; the master view by the environment
//               (decoder side and DRP primitives).
// Revision    : 1.0 - initial release
// ============================================================================
interface ul_drp_cfg_mp_if #(
  parameter int PORTS  = 4,
  parameter int ADDR_W = 7,
  parameter int GPIO_W = 4
);
  // command stream
  logic [31:0]              axis_in_data;
  logic                     axis_in_valid;
  logic                     axis_in_ready;
  // readback stream
  logic [31:0]              axis_out_data;
  logic                     axis_out_valid;
  logic                     axis_out_ready;
  // DRP bus, shared fields plus one-hot enable
  logic                     drp_clk;
  logic [15:0]              drp_di;
  logic [ADDR_W-1:0]        drp_daddr;
  logic                     drp_dwe;
  logic [PORTS-1:0]         drp_den;
  logic [16*PORTS-1:0]      drp_do;
  logic [PORTS-1:0]         drp_drdy;
  // per-port GPIO
  logic [GPIO_W*PORTS-1:0]  drp_gpio_out;
  logic [GPIO_W*PORTS-1:0]  drp_gpio_in;

  // environment side: issues commands, models the DRP primitives
  modport master (
    output axis_in_data, axis_in_valid, axis_out_ready,
    input  axis_in_ready, axis_out_data, axis_out_valid,
    input  drp_clk, drp_di, drp_daddr, drp_dwe, drp_den, drp_gpio_out,
    output drp_do, drp_drdy, drp_gpio_in
  );

  // bridge side
  modport slave (
    input  axis_in_data, axis_in_valid, axis_out_ready,
    output axis_in_ready, axis_out_data, axis_out_valid,
    output drp_clk, drp_di, drp_daddr, drp_dwe, drp_den, drp_gpio_out,
    input  drp_do, drp_drdy, drp_gpio_in
  );
endinterface
`default_nettype wire

// File: rtl/ul_drp_cfg_mp.sv
`default_nettype none
// ============================================================================
// Module      : ul_drp_cfg_mp
// Description : Multi-port DRP/GPIO configuration bridge. Decodes 32-bit
//               command words into per-port GPIO nibble writes or single DRP
//               transactions on one of PORTS DRP ports, and presents read
//               data, sticky TOUT/ERR, busy and the selected port's GPIO
//               inputs on a constantly valid readback word.
//               Optional feature macro: UL_DRP_TIMEOUT_EN enables a WAIT
//               watchdog that aborts after TIMEOUT cycles without drdy.
// Revision    : 1.0 - initial release
// ============================================================================
module ul_drp_cfg_mp #(
  parameter int                      PORTS      = 4,
  parameter int                      ADDR_W     = 7,
  parameter int                      GPIO_W     = 4,
  parameter logic [PORTS*GPIO_W-1:0] GPIO_RESET = '0,
  parameter int                      TIMEOUT    = 255
) (
  input  wire logic      axis_clk,
  input  wire logic      reset,
  ul_drp_cfg_mp_if.slave bus
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_REQ  = 2'd1;
  localparam logic [1:0] c_ST_WAIT = 2'd2;

  // command field decode
  logic [31:0]       w_cmd;
  logic [15:0]       w_di;
  logic [ADDR_W-1:0] w_addr;
  logic              w_regen;
  logic              w_regwr;
  logic [4:0]        w_sel;
  logic              w_sel_ok;
  logic              w_acc;
  logic              w_drp_go;
  logic              w_gpio_go;
  logic              w_bad;

  // FSM and datapath state
  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic                    r_ready;
  logic                    w_ready_d;
  logic [PORTS-1:0]        r_den;
  logic [PORTS-1:0]        w_den_d;
  logic [15:0]             r_di;
  logic [ADDR_W-1:0]       r_daddr;
  logic                    r_dwe;
  logic [4:0]              r_sel;
  logic [4:0]              r_rb_sel;
  logic [PORTS*GPIO_W-1:0] r_gpio_out;
  logic [15:0]             r_rdata;
  logic                    r_tout;
  logic                    r_err;

  // selected-port views
  logic              w_drdy_sel;
  logic [15:0]       w_do_sel;
  logic [GPIO_W-1:0] w_gpio_rb;
  logic              w_tmo;

  assign w_cmd     = bus.axis_in_data;
  assign w_di      = w_cmd[15:0];
  assign w_addr    = w_cmd[16 +: ADDR_W];
  assign w_regen   = w_cmd[25];
  assign w_regwr   = w_cmd[26];
  assign w_sel     = w_cmd[31:27];
  // 6-bit compare so PORTS=32 still fits
  assign w_sel_ok  = ({1'b0, w_sel} < 6'(PORTS));
  // ready is high only in IDLE, so every accept happens in IDLE
  assign w_acc     = bus.axis_in_valid & r_ready;
  assign w_drp_go  = w_acc & w_regen & w_sel_ok;
  assign w_gpio_go = w_acc & ~w_regen & w_sel_ok;
  assign w_bad     = w_acc & ~w_sel_ok;

  // route the active DRP port's drdy and read data
  always_comb begin
    w_drdy_sel = 1'b0;
    w_do_sel   = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (r_sel == 5'(p)) begin
        w_drdy_sel = bus.drp_drdy[p];
        w_do_sel   = bus.drp_do[p*16 +: 16];
      end
    end
  end

  // route the readback-selected port's GPIO inputs (combinational path)
  always_comb begin
    w_gpio_rb = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (r_rb_sel == 5'(p)) begin
        w_gpio_rb = bus.drp_gpio_in[p*GPIO_W +: GPIO_W];
      end
    end
  end

`ifdef UL_DRP_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;

  // WAIT watchdog: cleared outside WAIT, fires on the TIMEOUT-th WAIT cycle
  always_ff @(posedge axis_clk) begin
    if (reset || (r_state != c_ST_WAIT)) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  assign w_tmo = (r_state == c_ST_WAIT) && (r_tmo_cnt == 16'(TIMEOUT - 1));
`else
  logic w_unused_tmo;
  assign w_tmo        = 1'b0;
  assign w_unused_tmo = &{1'b0, 32'(TIMEOUT)};
`endif

  // FSM state register
  always_ff @(posedge axis_clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state; a timeout coinciding with drdy still completes normally
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_drp_go) w_state_nxt = c_ST_REQ;
      c_ST_REQ:  w_state_nxt = c_ST_WAIT;
      c_ST_WAIT: if (w_drdy_sel || w_tmo) w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // FSM outputs computed from the next state so they can be registered
  always_comb begin
    w_ready_d = (w_state_nxt == c_ST_IDLE);
    w_den_d   = '0;
    for (int p = 0; p < PORTS; p++) begin
      // REQ is only entered from an accepted command, so w_sel is the target
      if ((w_state_nxt == c_ST_REQ) && (w_sel == 5'(p))) begin
        w_den_d[p] = 1'b1;
      end
    end
  end

  // datapath: DRP fields, GPIO outputs, read data and sticky flags
  always_ff @(posedge axis_clk) begin
    if (reset) begin
      r_ready    <= 1'b1;
      r_den      <= '0;
      r_di       <= '0;
      r_daddr    <= '0;
      r_dwe      <= 1'b0;
      r_sel      <= '0;
      r_rb_sel   <= '0;
      r_gpio_out <= GPIO_RESET;
      r_rdata    <= '0;
      r_tout     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ready <= w_ready_d;
      r_den   <= w_den_d;
      if (w_drp_go) begin
        r_di    <= w_di;
        r_daddr <= w_addr;
        r_dwe   <= w_regwr;
        r_sel   <= w_sel;
        r_tout  <= 1'b0;
        r_err   <= 1'b0;
      end
      if (w_bad) begin
        r_err <= 1'b1;
      end
      if (w_gpio_go) begin
        r_rb_sel <= w_sel;
      end
      for (int p = 0; p < PORTS; p++) begin
        if (w_gpio_go && (w_sel == 5'(p))) begin
          r_gpio_out[p*GPIO_W +: GPIO_W] <= w_cmd[GPIO_W-1:0];
        end
      end
      if (r_state == c_ST_WAIT) begin
        if (w_drdy_sel) begin
          r_rdata <= w_do_sel;
        end else if (w_tmo) begin
          r_rdata <= 16'hFFFF;
          r_tout  <= 1'b1;
        end
      end
    end
  end

  // unused inputs: readback is always valid, high command bits are don't-care
  logic w_unused_in;
  assign w_unused_in = &{1'b0, bus.axis_out_ready, w_cmd};

  assign bus.axis_in_ready  = r_ready;
  assign bus.axis_out_valid = 1'b1;
  assign bus.axis_out_data  = {8'(w_gpio_rb), 5'b0, (r_state != c_ST_IDLE),
                               r_err, r_tout, r_rdata};
  assign bus.drp_clk        = axis_clk;
  assign bus.drp_di         = r_di;
  assign bus.drp_daddr      = r_daddr;
  assign bus.drp_dwe        = r_dwe;
  assign bus.drp_den        = r_den;
  assign bus.drp_gpio_out   = r_gpio_out;

endmodule
`default_nettype wire
